// File: rtl/turf_frame_reader.sv
// rtl/turf_frame_reader.sv - playfield RAM sweeper feeding the VGA plot interface and tallying territory
//
// Sweeps the X_MAX x Y_MAX playfield once per accepted start, reading the RAM
// through a synchronous read port (one cycle latency), replaying every pixel to
// the VGA adapter and counting cells owned by each player. Tallies are published
// when the frame completes and hold until the next completed frame or reset.
//
// Ports:
//   CLOCK_50     in   system clock, rising-edge
//   resetn       in   asynchronous active-low reset
//   start        in   frame request, honoured only in IDLE
//   rd_address   out  RAM read address {x[7:0], y[6:0]}
//   rd_q         in   RAM read data, valid one cycle after rd_address
//   x, y         out  plot coordinates
//   colour       out  plot colour (RAM word)
//   plot         out  x/y/colour valid this cycle
//   busy         out  frame in progress
//   done         out  one-cycle pulse at frame completion
//   score_p1..p4 out  cells of colour 001/010/100/110 in the last completed frame
//   dead_cells   out  cells of colour 111 in the last completed frame

module turf_frame_reader #(
    parameter int X_MAX = 160,
    parameter int Y_MAX = 120,
    parameter int CNT_W = 15
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             start,
    output logic [14:0]      rd_address,
    input  logic [2:0]       rd_q,
    output logic [7:0]       x,
    output logic [6:0]       y,
    output logic [2:0]       colour,
    output logic             plot,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] score_p1,
    output logic [CNT_W-1:0] score_p2,
    output logic [CNT_W-1:0] score_p3,
    output logic [CNT_W-1:0] score_p4,
    output logic [CNT_W-1:0] dead_cells
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t           state_q;

    // scan counters and their next values
    logic [7:0]       sx_q;
    logic [7:0]       sx_d;
    logic [6:0]       sy_q;
    logic [6:0]       sy_d;
    logic             last_col;
    logic             last_issue;
    logic             accept;

    // address issue stage
    logic [14:0]      rd_address_q;
    logic             v0_q;

    // stage aligned with rd_q
    logic [14:0]      a1_q;
    logic             v1_q;

    // plot stage
    logic [7:0]       x_q;
    logic [6:0]       y_q;
    logic [2:0]       colour_q;
    logic             plot_q;

    logic             busy_q;
    logic             done_q;
    logic             drain_cnt_q;

    logic [CNT_W-1:0] acc_p1_q;
    logic [CNT_W-1:0] acc_p2_q;
    logic [CNT_W-1:0] acc_p3_q;
    logic [CNT_W-1:0] acc_p4_q;
    logic [CNT_W-1:0] acc_dead_q;

    logic [CNT_W-1:0] score_p1_q;
    logic [CNT_W-1:0] score_p2_q;
    logic [CNT_W-1:0] score_p3_q;
    logic [CNT_W-1:0] score_p4_q;
    logic [CNT_W-1:0] dead_cells_q;

    always_comb begin
        last_col   = (sx_q == 8'(X_MAX - 1));
        last_issue = last_col && (sy_q == 7'(Y_MAX - 1));
        sx_d       = last_col ? 8'd0 : sx_q + 8'd1;
        sy_d       = last_col ? sy_q + 7'd1 : sy_q;
        accept     = (state_q == S_IDLE) && start;
    end

    // Frame sequencing: address issue, drain timing, publication of results.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            sx_q         <= '0;
            sy_q         <= '0;
            rd_address_q <= '0;
            v0_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            drain_cnt_q  <= 1'b0;
            score_p1_q   <= '0;
            score_p2_q   <= '0;
            score_p3_q   <= '0;
            score_p4_q   <= '0;
            dead_cells_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    rd_address_q <= '0;
                    v0_q         <= 1'b0;
                    if (start) begin
                        sx_q    <= '0;
                        sy_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    rd_address_q <= {sx_q, sy_q};
                    v0_q         <= 1'b1;
                    sx_q         <= sx_d;
                    sy_q         <= sy_d;
                    if (last_issue) begin
                        drain_cnt_q <= 1'b0;
                        state_q     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Two cycles let the final address clear the RAM and plot stages.
                    rd_address_q <= '0;
                    v0_q         <= 1'b0;
                    if (drain_cnt_q) begin
                        state_q <= S_FINISH;
                    end else begin
                        drain_cnt_q <= 1'b1;
                    end
                end
                S_FINISH: begin
                    score_p1_q   <= acc_p1_q;
                    score_p2_q   <= acc_p2_q;
                    score_p3_q   <= acc_p3_q;
                    score_p4_q   <= acc_p4_q;
                    dead_cells_q <= acc_dead_q;
                    done_q       <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Read pipeline and territory tally. The address stage is delayed one
    // cycle so that a1_q/v1_q line up with rd_q coming back from the RAM.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            a1_q       <= '0;
            v1_q       <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            plot_q     <= 1'b0;
            acc_p1_q   <= '0;
            acc_p2_q   <= '0;
            acc_p3_q   <= '0;
            acc_p4_q   <= '0;
            acc_dead_q <= '0;
        end else begin
            a1_q   <= rd_address_q;
            v1_q   <= v0_q;
            plot_q <= v1_q;
            if (v1_q) begin
                x_q      <= a1_q[14:7];
                y_q      <= a1_q[6:0];
                colour_q <= rd_q;
            end
            // The pipeline is empty whenever a frame is accepted, so clearing
            // and counting never coincide.
            if (accept) begin
                acc_p1_q   <= '0;
                acc_p2_q   <= '0;
                acc_p3_q   <= '0;
                acc_p4_q   <= '0;
                acc_dead_q <= '0;
            end else if (v1_q) begin
                case (rd_q)
                    3'b001:  acc_p1_q   <= acc_p1_q + 1'b1;
                    3'b010:  acc_p2_q   <= acc_p2_q + 1'b1;
                    3'b100:  acc_p3_q   <= acc_p3_q + 1'b1;
                    3'b110:  acc_p4_q   <= acc_p4_q + 1'b1;
                    3'b111:  acc_dead_q <= acc_dead_q + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign rd_address = rd_address_q;
    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign score_p1   = score_p1_q;
    assign score_p2   = score_p2_q;
    assign score_p3   = score_p3_q;
    assign score_p4   = score_p4_q;
    assign dead_cells = dead_cells_q;

endmodule

// File: tb/tb_turf_frame_reader.sv
// tb/tb_turf_frame_reader.sv - self-checking bench for turf_frame_reader

module tb_turf_frame_reader;

    localparam int XM   = 160;
    localparam int YM   = 120;
    localparam int NPIX = XM * YM;
    // start-sample cycle counted as cycle 1: IDLE->SCAN, scan, drain, finish
    localparam int LAT    = 1 + NPIX + 2 + 1;
    // one loop of the state machine under a held start: IDLE, scan, drain, finish
    localparam int PERIOD = 1 + NPIX + 2 + 1;

    logic        CLOCK_50;
    logic        resetn;
    logic        start;
    logic [14:0] rd_address;
    logic [2:0]  rd_q;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;
    logic [14:0] score_p1;
    logic [14:0] score_p2;
    logic [14:0] score_p3;
    logic [14:0] score_p4;
    logic [14:0] dead_cells;

    logic [2:0]  mem [0:32767];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int idx        = 0;
    int ndone      = 0;
    int e_p1, e_p2, e_p3, e_p4, e_dead;

    turf_frame_reader dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .start      (start),
        .rd_address (rd_address),
        .rd_q       (rd_q),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .score_p3   (score_p3),
        .score_p4   (score_p4),
        .dead_cells (dead_cells)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // synchronous-read playfield RAM
    always @(posedge CLOCK_50) rd_q <= mem[rd_address];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [2:0] v);
        for (int i = 0; i < 32768; i++) mem[i] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32768; i++) mem[i] = 3'($urandom_range(0, 7));
    endtask

    // Territory totals straight from the playfield contents.
    task automatic model();
        e_p1 = 0; e_p2 = 0; e_p3 = 0; e_p4 = 0; e_dead = 0;
        for (int xx = 0; xx < XM; xx++) begin
            for (int yy = 0; yy < YM; yy++) begin
                case (mem[xx * 128 + yy])
                    3'b001:  e_p1++;
                    3'b010:  e_p2++;
                    3'b100:  e_p3++;
                    3'b110:  e_p4++;
                    3'b111:  e_dead++;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_scores(input string tag);
        chk({tag, "_p1"},   score_p1,   e_p1);
        chk({tag, "_p2"},   score_p2,   e_p2);
        chk({tag, "_p3"},   score_p3,   e_p3);
        chk({tag, "_p4"},   score_p4,   e_p4);
        chk({tag, "_dead"}, dead_cells, e_dead);
    endtask

    task automatic wait_done(output int c);
        int n;
        n = 0;
        while (!done && n < 25000) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("done_in_time", done, 1);
        c = cyc;
    endtask

    initial begin
        int c0, c1, c2, c3, nd;

        resetn = 1'b0;
        start  = 1'b0;
        fill(3'b000);

        // plot-stream monitor: pixel i of a frame is (i % XM, i / XM)
        fork
            forever begin
                @(posedge CLOCK_50);
                #2;
                if (!resetn) begin
                    idx = 0;
                end else begin
                    if (idx > 0 && idx < NPIX) chk("plot_contig", plot, 1);
                    if (plot) begin
                        chk("plot_x", x, idx % XM);
                        chk("plot_y", y, idx / XM);
                        chk("plot_colour", colour, mem[(idx % XM) * 128 + idx / XM]);
                        idx++;
                    end
                    if (done) begin
                        chk("plots_per_frame", idx, NPIX);
                        ndone++;
                        idx = 0;
                    end
                end
            end
        join_none

        repeat (3) @(negedge CLOCK_50);
        chk("rst_rd_address", rd_address, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        e_p1 = 0; e_p2 = 0; e_p3 = 0; e_p4 = 0; e_dead = 0;
        check_scores("rst");

        resetn = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        chk("idle_rd_address", rd_address, 0);
        chk("idle_busy", busy, 0);

        // Frame A: empty playfield, start held high for the next three frames
        start = 1'b1;
        c0 = cyc;
        @(negedge CLOCK_50);
        chk("busy_after_start", busy, 1);
        model();
        wait_done(c1);
        chk("latency_A", c1 - c0, LAT);
        chk("busy_at_done_A", busy, 0);
        check_scores("A");

        // Frame B: five marked cells on an empty field
        fill(3'b000);
        mem[0 * 128 + 0]     = 3'b001;
        mem[159 * 128 + 0]   = 3'b010;
        mem[0 * 128 + 1]     = 3'b100;
        mem[159 * 128 + 119] = 3'b110;
        mem[5 * 128 + 5]     = 3'b111;
        repeat (3000) @(negedge CLOCK_50);
        chk("busy_mid_B", busy, 1);
        check_scores("hold_mid_B");
        model();
        wait_done(c2);
        chk("period_AB", c2 - c1, PERIOD);
        check_scores("B");
        chk("B_p1_single", score_p1, 1);

        // Frame C: whole field owned by player 1
        fill(3'b001);
        repeat (3000) @(negedge CLOCK_50);
        check_scores("hold_mid_C");
        model();
        wait_done(c3);
        chk("period_BC", c3 - c2, PERIOD);
        check_scores("C");
        chk("C_p1_full", score_p1, NPIX);

        // Frame D starts from the held start; abort it with reset
        nd = ndone;
        repeat (10000) @(negedge CLOCK_50);
        chk("busy_before_abort", busy, 1);
        resetn = 1'b0;
        start  = 1'b0;
        #1;
        chk("abort_plot", plot, 0);
        chk("abort_busy", busy, 0);
        e_p1 = 0; e_p2 = 0; e_p3 = 0; e_p4 = 0; e_dead = 0;
        check_scores("abort");
        repeat (3) @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        chk("abort_no_done", ndone - nd, 0);
        chk("abort_idle_busy", busy, 0);

        // Frame E: random field, second start pulse mid-sweep is ignored
        fill_random();
        model();
        nd = ndone;
        start = 1'b1;
        c0 = cyc;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (498) @(negedge CLOCK_50);
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        wait_done(c1);
        chk("latency_E", c1 - c0, LAT);
        check_scores("E");
        repeat (40) @(negedge CLOCK_50);
        chk("one_done_E", ndone - nd, 1);
        chk("idle_after_E_busy", busy, 0);
        chk("idle_after_E_plot", plot, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
